rs485_poll_ctrl: RTL

//  Half-duplex RS-485 master for one telemetry slave: sends a 1-byte request, turns the bus around, then receives
//  a fixed-length response. Each received byte goes to a write port feeding the orbital frame buffer.

---
 rtl/rs485_poll_pkg.sv | 22 ++
 rtl/rs485_uart_rx_byte.sv | 86 ++++++++
 rtl/rs485_poll_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rs485_poll_pkg.sv
// Shared constants for the RS-485 telemetry poller: FSM encodings and status bit positions.
package rs485_poll_pkg;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StTxGuard   = 3'd1;
    localparam logic [2:0] StTxByte    = 3'd2;
    localparam logic [2:0] StTxRelease = 3'd3;
    localparam logic [2:0] StRxWait    = 3'd4;
    localparam logic [2:0] StRxByte    = 3'd5;
    localparam logic [2:0] StRxGap     = 3'd6;
    localparam logic [2:0] StFinish    = 3'd7;

    localparam logic [1:0] RxIdle  = 2'd0;
    localparam logic [1:0] RxStart = 2'd1;
    localparam logic [1:0] RxData  = 2'd2;

    localparam int unsigned ST_TIMEOUT = 0;
    localparam int unsigned ST_FRAME   = 1;
    localparam int unsigned ST_ECHO    = 2;
    localparam int unsigned ST_CSUM    = 3;

endpackage

// File: rtl/rs485_uart_rx_byte.sv
// UART byte receiver: 2-FF synchroniser, mid-bit start validation, 8N1 sampling and stop check.
module rs485_uart_rx_byte
    import rs485_poll_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 33
) (
    input  logic       clk80MHz,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx_in,
    output logic       rx_busy,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] byte_data
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]    phase_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [7:0]    shift_q;
    logic          stop_sample;

    always_ff @(posedge clk80MHz or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            phase_q   <= RxIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_s1_q   <= rx_in;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (!rx_en) begin
                phase_q <= RxIdle;
            end else begin
                case (phase_q)
                    RxIdle: begin
                        if (rx_prev_q && !rx_s2_q) begin
                            phase_q <= RxStart;
                            cnt_q   <= '0;
                        end
                    end
                    RxStart: begin
                        if (cnt_q == HALF_M1) begin
                            // A line that is high again at mid-start was only a glitch.
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            phase_q <= rx_s2_q ? RxIdle : RxData;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RxData: begin
                        if (cnt_q == FULL_M1) begin
                            cnt_q <= '0;
                            if (bit_q == 4'd8) begin
                                phase_q <= RxIdle;
                            end else begin
                                shift_q <= {rx_s2_q, shift_q[7:1]};
                                bit_q   <= bit_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: phase_q <= RxIdle;
                endcase
            end
        end
    end

    assign stop_sample = (phase_q == RxData) && (cnt_q == FULL_M1) && (bit_q == 4'd8);
    assign byte_valid  = stop_sample && rx_s2_q;
    assign frame_err   = stop_sample && !rx_s2_q;
    assign byte_data   = shift_q;
    assign rx_busy     = (phase_q == RxData);

endmodule

// File: rtl/rs485_poll_ctrl.sv
// Half-duplex RS-485 poll master: request byte out, fixed-length response in to a write port.
// Define POLL_CHECKSUM_EN to check the last response byte as a mod-256 sum of the others.
module rs485_poll_ctrl
    import rs485_poll_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT      = 33,
    parameter int unsigned PKT_LEN           = 20,
    parameter int unsigned TURN_CLKS         = 64,
    parameter int unsigned RESP_TIMEOUT_BITS = 64,
    parameter int unsigned GAP_TIMEOUT_BITS  = 20
) (
    input  logic                       clk80MHz,
    input  logic                       rst,
    input  logic                       poll_req,
    input  logic [7:0]                 poll_addr,
    output logic                       busy,
    output logic                       done,
    output logic [3:0]                 status,
    output logic                       wr_en,
    output logic [$clog2(PKT_LEN)-1:0] wr_addr,
    output logic [7:0]                 wr_data,
    output logic                       UART_TX,
    input  logic                       UART_RX,
    output logic                       UART_dTX,
    output logic                       UART_dRX
);

    localparam int unsigned IDX_W = $clog2(PKT_LEN);
    localparam logic [15:0] TURN_M1 = 16'(TURN_CLKS - 1);
    localparam logic [15:0] CLKS_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] RESP_M1 = 16'(RESP_TIMEOUT_BITS - 1);
    localparam logic [15:0] GAP_M1  = 16'(GAP_TIMEOUT_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    logic [2:0]       state_q;
    logic [15:0]      cnt_q, bit_q;
    logic [7:0]       addr_q;
    logic [8:0]       tx_sr_q;
    logic             tx_q, busy_q, done_q, wr_en_q;
    logic [3:0]       status_q;
    logic [IDX_W-1:0] idx_q, wr_addr_q;
    logic [7:0]       wr_data_q;
`ifdef POLL_CHECKSUM_EN
    logic [7:0]       sum_q;
`endif

    logic       rx_en, rx_busy, byte_valid, frame_err;
    logic [7:0] byte_data;

    assign rx_en = (state_q == StRxWait) || (state_q == StRxByte) || (state_q == StRxGap);

    rs485_uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk80MHz  (clk80MHz),
        .rst       (rst),
        .rx_en     (rx_en),
        .rx_in     (UART_RX),
        .rx_busy   (rx_busy),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .byte_data (byte_data)
    );

    always_ff @(posedge clk80MHz or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            addr_q    <= '0;
            tx_sr_q   <= '1;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef POLL_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            if (done_q) busy_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // busy_q is still high during the done cycle, so a request there is dropped.
                    if (poll_req && !busy_q) begin
                        busy_q   <= 1'b1;
                        addr_q   <= poll_addr;
                        status_q <= '0;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= StTxGuard;
`ifdef POLL_CHECKSUM_EN
                        sum_q    <= '0;
`endif
                    end
                end
                StTxGuard: begin
                    if (cnt_q == TURN_M1) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        tx_sr_q <= {1'b1, addr_q};
                        state_q <= StTxByte;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StTxByte: begin
                    if (cnt_q == CLKS_M1) begin
                        cnt_q <= '0;
                        if (bit_q == 16'd9) begin
                            state_q <= StTxRelease;
                        end else begin
                            tx_q    <= tx_sr_q[0];
                            tx_sr_q <= {1'b1, tx_sr_q[8:1]};
                            bit_q   <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StTxRelease: begin
                    if (cnt_q == TURN_M1) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= StRxWait;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRxWait, StRxGap: begin
                    if (rx_busy) begin
                        state_q <= StRxByte;
                    end else if (cnt_q == CLKS_M1) begin
                        cnt_q <= '0;
                        if (bit_q == ((state_q == StRxWait) ? RESP_M1 : GAP_M1)) begin
                            status_q[ST_TIMEOUT] <= 1'b1;
                            state_q              <= StFinish;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRxByte: begin
                    if (byte_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= idx_q;
                        wr_data_q <= byte_data;
                        if (idx_q == '0 && byte_data != addr_q) status_q[ST_ECHO] <= 1'b1;
`ifdef POLL_CHECKSUM_EN
                        if (idx_q == LAST_IDX) begin
                            if (byte_data != sum_q) status_q[ST_CSUM] <= 1'b1;
                        end else begin
                            sum_q <= sum_q + byte_data;
                        end
`endif
                        if (idx_q == LAST_IDX) begin
                            state_q <= StFinish;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= StRxGap;
                        end
                    end else if (frame_err) begin
                        status_q[ST_FRAME] <= 1'b1;
                        state_q            <= StFinish;
                    end
                end
                StFinish: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Both enables decode from one state register, so DE and /RE can never overlap.
    assign UART_dTX = (state_q == StTxGuard) || (state_q == StTxByte) || (state_q == StTxRelease);
    assign UART_dRX = !rx_en;
    assign UART_TX  = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign status   = status_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule
